// File: rtl/fp_addsub_param.sv
// rtl/fp_addsub_param.sv - multi-cycle floating-point adder/subtractor (flush-to-zero)
//
// Purpose: adds or subtracts two {sign, exponent, fraction} operands using a
// sequential IDLE/ALIGN/ADD/NORM/ROUND/DONE datapath, one operation in flight.
// Optional feature: define FP_ADDSUB_RNE_EN for round-to-nearest-even,
// otherwise ROUND truncates (same latency).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE)
//   op                  0 = a+b, 1 = a-b
//   a, b                operands, W = 1+EXP_W+MAN_W bits
//   out_valid/out_ready result handshake (held in DONE)
//   result              sum
//   overflow, underflow, zero  status for the current result

module fp_addsub_param #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         zero
);

    // Working mantissa: {hidden, fraction, guard, round, sticky}
    localparam int MW = MAN_W + 4;
    localparam int SW = MAN_W + 5;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t           state_q, state_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d;
    logic [MW-1:0]    ma_q, ma_d, mb_q, mb_d;
    logic             fixed_q, fixed_d;     // result already final, ROUND just passes through
    logic [W-1:0]     res_q, res_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [EXP_W-1:0] exp_diff, ea_inc;
    logic [SW-1:0]    sum;
    logic             sum_sign;
    logic [MAN_W:0]   frac_rnd;
    logic             inc;

    assign a_exp = a[W-2:MAN_W];
    assign b_exp = b[W-2:MAN_W];

    // Right shift by one with the shifted-out bit folded into sticky
    function automatic logic [MW-1:0] shr1(input logic [MW-1:0] m);
        return {1'b0, m[MW-1:2], m[1] | m[0]};
    endfunction

    function automatic logic [MW-1:0] flush_sticky(input logic [MW-1:0] m);
        return {{(MW-1){1'b0}}, |m};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            fixed_q <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            fixed_q <= fixed_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        fixed_d  = fixed_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        zero_d   = zero_q;
        exp_diff = (ea_q > eb_q) ? (ea_q - eb_q) : (eb_q - ea_q);
        ea_inc   = ea_q + EXP_W'(1);
        sum      = '0;
        sum_sign = sa_q;
        frac_rnd = '0;
        inc      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sa_d    = a[W-1];
                    sb_d    = b[W-1] ^ op;
                    ea_d    = a_exp;
                    eb_d    = b_exp;
                    // Exponent zero means zero (subnormals flushed), so hidden and fraction drop
                    ma_d    = (a_exp == '0) ? '0 : {1'b1, a[MAN_W-1:0], 3'b000};
                    mb_d    = (b_exp == '0) ? '0 : {1'b1, b[MAN_W-1:0], 3'b000};
                    fixed_d = 1'b0;
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    zero_d  = 1'b0;
                    if (a_exp == EXP_ONES) begin
                        res_d   = {a[W-1], EXP_ONES, {MAN_W{1'b0}}};
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else if (b_exp == EXP_ONES) begin
                        res_d   = {b[W-1] ^ op, EXP_ONES, {MAN_W{1'b0}}};
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (ea_q == '0 || eb_q == '0) begin
                    // A zero operand takes the other's exponent; its mantissa is already 0
                    ea_d    = (ea_q > eb_q) ? ea_q : eb_q;
                    eb_d    = (ea_q > eb_q) ? ea_q : eb_q;
                    state_d = ADD;
                end else if (ea_q == eb_q) begin
                    state_d = ADD;
                end else if (int'(exp_diff) > MAN_W + 3) begin
                    if (ea_q < eb_q) begin
                        ma_d = flush_sticky(ma_q);
                        ea_d = eb_q;
                    end else begin
                        mb_d = flush_sticky(mb_q);
                        eb_d = ea_q;
                    end
                    state_d = ADD;
                end else if (ea_q < eb_q) begin
                    ma_d = shr1(ma_q);
                    ea_d = ea_inc;
                end else begin
                    mb_d = shr1(mb_q);
                    eb_d = eb_q + EXP_W'(1);
                end
            end
            ADD: begin
                if (sa_q == sb_q) begin
                    sum      = {1'b0, ma_q} + {1'b0, mb_q};
                    sum_sign = sa_q;
                end else if (ma_q >= mb_q) begin
                    sum      = {1'b0, ma_q} - {1'b0, mb_q};
                    sum_sign = sa_q;
                end else begin
                    sum      = {1'b0, mb_q} - {1'b0, ma_q};
                    sum_sign = sb_q;
                end
                sa_d = sum_sign;
                if (sum == '0) begin
                    res_d   = '0;
                    zero_d  = 1'b1;
                    fixed_d = 1'b1;
                    state_d = ROUND;
                end else if (sum[SW-1]) begin
                    ma_d = {sum[SW-1:2], sum[1] | sum[0]};
                    ea_d = ea_inc;
                    if (ea_inc == EXP_ONES) begin
                        res_d   = {sum_sign, EXP_ONES, {MAN_W{1'b0}}};
                        ovf_d   = 1'b1;
                        fixed_d = 1'b1;
                        state_d = ROUND;
                    end else begin
                        state_d = NORM;
                    end
                end else begin
                    ma_d    = sum[MW-1:0];
                    state_d = NORM;
                end
            end
            NORM: begin
                if (ma_q[MW-1]) begin
                    state_d = ROUND;
                end else if (ea_q == EXP_W'(1)) begin
                    // Next shift would make the exponent 0: flush to +0
                    res_d   = '0;
                    unf_d   = 1'b1;
                    zero_d  = 1'b1;
                    fixed_d = 1'b1;
                    state_d = ROUND;
                end else begin
                    ma_d = ma_q << 1;
                    ea_d = ea_q - EXP_W'(1);
                end
            end
            ROUND: begin
                if (!fixed_q) begin
`ifdef FP_ADDSUB_RNE_EN
                    inc = ma_q[2] & (ma_q[1] | ma_q[0] | ma_q[3]);
`else
                    inc = 1'b0;
`endif
                    frac_rnd = {1'b0, ma_q[MW-2:3]} + {{MAN_W{1'b0}}, inc};
                    // Fraction carry means mantissa became 2.0: renormalise
                    if (frac_rnd[MAN_W]) begin
                        res_d = {sa_q, ea_inc, {MAN_W{1'b0}}};
                        ovf_d = (ea_inc == EXP_ONES);
                    end else begin
                        res_d = {sa_q, ea_q, frac_rnd[MAN_W-1:0]};
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_fp_addsub_param.sv
// tb/tb_fp_addsub_param.sv - self-checking bench for fp_addsub_param (half-precision defaults)

module tb_fp_addsub_param;

`ifdef FP_ADDSUB_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;
    logic        underflow;
    logic        zero;

    fp_addsub_param dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] res;
        logic        ovf;
        logic        unf;
        logic        zro;
        int          lat;
    } vec_t;

    vec_t vecs[19];
    vec_t exp_q[$];
    int   checks;
    int   failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic vop,
                                input logic [15:0] vres, input logic vo, input logic vu,
                                input logic vz, input int vl);
        vec_t v;
        v.a = va; v.b = vb; v.op = vop; v.res = vres;
        v.ovf = vo; v.unf = vu; v.zro = vz; v.lat = vl;
        return v;
    endfunction

    // Drive one operation, wait for its result, compare, optionally hold out_ready low
    task automatic run_op(input vec_t v, input bit rel_rst, input int hold);
        vec_t e;
        int   lat;
        logic [15:0] held;
        @(negedge clk);
        if (rel_rst) rst_n = 1'b1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a = v.a; b = v.b; op = v.op; in_valid = 1'b1;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            check("timeout_out_valid", 32'(out_valid), 32'd1);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            check($sformatf("result a=%h b=%h op=%0d", e.a, e.b, e.op), 32'(result), 32'(e.res));
            check($sformatf("overflow a=%h b=%h", e.a, e.b), 32'(overflow), 32'(e.ovf));
            check($sformatf("underflow a=%h b=%h", e.a, e.b), 32'(underflow), 32'(e.unf));
            check($sformatf("zero a=%h b=%h", e.a, e.b), 32'(zero), 32'(e.zro));
            check($sformatf("latency a=%h b=%h", e.a, e.b), 32'(lat), 32'(e.lat));
            held = e.res;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check("hold_result", 32'(result), 32'(held));
                check("hold_out_valid", 32'(out_valid), 32'd1);
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int seen;
        checks   = 0;
        failures = 0;
        vecs[0]  = mk(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 0, 0, 0, 4);
        vecs[1]  = mk(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 0, 0, 1, 3);
        vecs[2]  = mk(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1, 0, 0, 3);
        vecs[3]  = mk(16'h0400, 16'h0401, 1'b1, 16'h0000, 0, 1, 1, 4);
        vecs[4]  = mk(16'h3C01, 16'h1000, 1'b0, RNE ? 16'h3C02 : 16'h3C01, 0, 0, 0, 15);
        vecs[5]  = mk(16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 1, 0, 0, 0);
        vecs[6]  = mk(16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 1, 0, 0, 0);
        vecs[7]  = mk(16'h0000, 16'h3C00, 1'b0, 16'h3C00, 0, 0, 0, 4);
        vecs[8]  = mk(16'h4000, 16'h3C00, 1'b1, 16'h3C00, 0, 0, 0, 6);
        vecs[9]  = mk(16'h3C00, 16'h4000, 1'b0, 16'h4200, 0, 0, 0, 5);
        vecs[10] = mk(16'h3C00, 16'h0001, 1'b0, 16'h3C00, 0, 0, 0, 4);
        vecs[11] = mk(16'h3C00, 16'h0400, 1'b0, 16'h3C00, 0, 0, 0, 4);
        vecs[12] = mk(16'hC000, 16'h3C00, 1'b0, 16'hBC00, 0, 0, 0, 6);
        vecs[13] = mk(16'h3555, 16'h3555, 1'b0, 16'h3955, 0, 0, 0, 4);
        vecs[14] = mk(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 0, 0, 0, 15);
        vecs[15] = mk(16'h3C00, 16'h1001, 1'b0, RNE ? 16'h3C01 : 16'h3C00, 0, 0, 0, 15);
        vecs[16] = mk(16'h3FFF, 16'h1000, 1'b0, RNE ? 16'h4000 : 16'h3FFF, 0, 0, 0, 15);
        vecs[17] = mk(16'h3C00, 16'hBC00, 1'b1, 16'h4000, 0, 0, 0, 4);
        vecs[18] = mk(16'h3C00, 16'h1400, 1'b0, 16'h3C01, 0, 0, 0, 14);

        rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", 32'({overflow, underflow, zero}), 32'd0);

        // First accept on the first rising edge after reset release
        run_op(vecs[0], 1'b1, 0);
        for (int i = 1; i < 19; i++) begin
            run_op(vecs[i], 1'b0, 0);
        end

        // Consumer stall: result must hold for 10 cycles
        run_op(vecs[0], 1'b0, 10);

        // Reset mid-ALIGN: operation discarded, nothing produced
        @(negedge clk);
        a = 16'h3C01; b = 16'h1000; op = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midalign_in_ready_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", 32'({overflow, underflow, zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("no_output_after_abort", 32'(seen), 32'd0);
        check("idle_after_abort", 32'(in_ready), 32'd1);
        run_op(vecs[9], 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_addsub_param.md
FP_ADDSUB_PARAM -- requirements
Module: fp_addsub_param

Interface
REQ-001 The block SHALL have parameter EXP_W, default 5, meaning exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 10, meaning stored fraction width; operand width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, operands and op valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, block can accept operands.
REQ-007 The block SHALL have port op, input, 1 bit, 0 = a+b, 1 = a-b.
REQ-008 The block SHALL have ports a and b, input, W bits each, the operands {sign, exponent, fraction}.
REQ-009 The block SHALL have port out_valid, output, 1 bit, result valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-011 The block SHALL have port result, output, W bits, the sum.
REQ-012 The block SHALL have ports overflow, underflow and zero, output, 1 bit each, status for the current result.

Function
REQ-013 FSM states SHALL be IDLE, ALIGN, ADD, NORM, ROUND and DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 On in_valid&&in_ready the block SHALL capture a, b and op, invert b's sign if op=1, and go to ALIGN.
REQ-015 Captured mantissas SHALL be {hidden, fraction, guard, round, sticky}; hidden=0 and the value is treated as zero when exponent==0, since subnormals are flushed.
REQ-016 An operand with exponent all-ones SHALL force result {its sign, all-ones, 0}, overflow=1, and a direct jump to DONE.
REQ-017 ALIGN SHALL shift the smaller-exponent mantissa right 1 bit per cycle, OR shifted-out bits into sticky, and increment its exponent; one cycle SHALL be spent when exponents are equal or either operand is zero.
REQ-018 If the exponent difference exceeds MAN_W+3, ALIGN SHALL flush the smaller mantissa to sticky-only in one cycle.
REQ-019 ADD SHALL perform sign-magnitude add/subtract with a width of MAN_W+5 including carry; on carry-out it SHALL shift right 1 (sticky preserved) and exponent+1; result sign is the sign of the larger magnitude.
REQ-020 An exactly-zero sum SHALL give result 0 (+0), zero=1, and skip to DONE via ROUND.
REQ-021 NORM SHALL shift left 1 bit per cycle while hidden==0, decrementing the exponent, and spend a minimum of 1 cycle.
REQ-022 If the exponent would reach 0 in NORM, the result SHALL flush to +0 with underflow=1 and zero=1.
REQ-023 ROUND SHALL apply the rounding mode (REQ-030); a rounding carry SHALL renormalise and increment the exponent.
REQ-024 An exponent reaching all-ones after ADD or ROUND SHALL give result {sign, all-ones, 0} and overflow=1.
REQ-025 DONE SHALL hold out_valid=1 and stable result and flags until out_ready=1, then return to IDLE; there is no output bypass, so at most one operation is in flight.
REQ-026 Latency SHALL be: out_valid rises after the 4th rising edge following the accepting edge when exponents are equal and no left shift is needed, plus 1 cycle per alignment shift and 1 cycle per extra normalisation shift.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, result=0 and all flags=0, regardless of the current state.
REQ-028 An operation interrupted by reset SHALL be discarded with no output produced.
REQ-029 The first accept SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-030 With macro FP_ADDSUB_RNE_EN defined, ROUND SHALL round to nearest, ties to even, using guard/round/sticky; undefined, ROUND SHALL truncate and consume 1 cycle with the same latency.

Verification
REQ-031 Scenario: a=0x3C00, b=0x3C00, op=0 -> result=0x4000, flags 0, out_valid 4 edges after accept.
REQ-032 Scenario: a=0x3C00, b=0x3C00, op=1 -> result=0x0000, zero=1.
REQ-033 Scenario: a=0x7BFF, b=0x7BFF, op=0 -> result=0x7C00, overflow=1.
REQ-034 Scenario: a=0x0400, b=0x0401, op=1 -> result=0x0000, underflow=1, zero=1.
REQ-035 Scenario: a=0x3C01, b=0x1000, op=0 -> result=0x3C02 with FP_ADDSUB_RNE_EN, 0x3C01 without.
REQ-036 Scenario: hold out_ready=0 for 10 cycles, then pulse rst_n low mid-ALIGN on the next operation -> result held stable with in_ready=0 during the hold; after reset, out_valid=0, in_ready=1 and no stale result.
